pipe_fwd_ctl: RTL and testbench

PIPE_FWD_CTL -- requirements
Module: pipe_fwd_ctl

---
 rtl/pipe_fwd_ctl_if.sv | 31 +++
 rtl/pipe_fwd_ctl.sv | 77 +++++++
 tb/tb_pipe_fwd_ctl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pipe_fwd_ctl_if.sv
// Decode-side hazard/forwarding bus: decode slot description in, forward selects and stall out.
interface pipe_fwd_ctl_if #(
  parameter int RN_W     = 5,
  parameter int FW_DEPTH = 3,
  parameter int CNT_W    = 16
);
  localparam int SEL_W = $clog2(FW_DEPTH + 1);

  logic             pause;
  logic             flush;
  logic             id_valid;
  logic [RN_W-1:0]  id_rs_n;
  logic [RN_W-1:0]  id_rt_n;
  logic [RN_W-1:0]  id_rd_n;
  logic             id_we;
  logic             id_load;
  logic [SEL_W-1:0] fw_rs_sel;
  logic [SEL_W-1:0] fw_rt_sel;
  logic             stall_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output pause, flush, id_valid, id_rs_n, id_rt_n, id_rd_n, id_we, id_load,
    input  fw_rs_sel, fw_rt_sel, stall_o, stall_cnt_o
  );

  modport slave (
    input  pause, flush, id_valid, id_rs_n, id_rt_n, id_rd_n, id_we, id_load,
    output fw_rs_sel, fw_rt_sel, stall_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_fwd_ctl.sv
// Tracks in-flight destination registers, picks forwarding sources for decode
// operands and raises a load-use stall with a saturating stall counter.
module pipe_fwd_ctl #(
  parameter int RN_W     = 5,
  parameter int FW_DEPTH = 3,
  parameter int CNT_W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  pipe_fwd_ctl_if.slave bus
);
  localparam int SEL_W = $clog2(FW_DEPTH + 1);

  logic            vld_reg [FW_DEPTH];
  logic            we_reg  [FW_DEPTH];
  logic            ld_reg  [FW_DEPTH];
  logic [RN_W-1:0] rd_reg  [FW_DEPTH];
  logic [CNT_W-1:0] cnt_reg;

  logic [FW_DEPTH-1:0] rs_hit;
  logic [FW_DEPTH-1:0] rt_hit;
  logic [SEL_W-1:0]    rs_sel_next;
  logic [SEL_W-1:0]    rt_sel_next;
  logic                stall_next;

  // Register 0 is hard-wired, so it never matches a tracked writer.
  for (genvar gi = 0; gi < FW_DEPTH; gi++) begin : g_hit
    assign rs_hit[gi] = vld_reg[gi] && we_reg[gi] && (rd_reg[gi] == bus.id_rs_n)
                        && (bus.id_rs_n != '0);
    assign rt_hit[gi] = vld_reg[gi] && we_reg[gi] && (rd_reg[gi] == bus.id_rt_n)
                        && (bus.id_rt_n != '0);
  end

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    rs_sel_next = '0;
    rt_sel_next = '0;
    for (int i = FW_DEPTH - 1; i >= 0; i--) begin
      if (rs_hit[i]) rs_sel_next = SEL_W'(i + 1);
      if (rt_hit[i]) rt_sel_next = SEL_W'(i + 1);
    end
  end

  assign stall_next = bus.id_valid && ld_reg[0] && (rs_hit[0] || rt_hit[0]);

  assign bus.fw_rs_sel   = rst ? rs_sel_next : '0;
  assign bus.fw_rt_sel   = rst ? rt_sel_next : '0;
  assign bus.stall_o     = rst && stall_next;
  assign bus.stall_cnt_o = cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FW_DEPTH; i++) begin
        vld_reg[i] <= 1'b0;
        we_reg[i]  <= 1'b0;
        ld_reg[i]  <= 1'b0;
        rd_reg[i]  <= '0;
      end
      cnt_reg <= '0;
    end else if (!bus.pause) begin
      for (int i = 1; i < FW_DEPTH; i++) begin
        vld_reg[i] <= vld_reg[i-1];
        we_reg[i]  <= we_reg[i-1];
        ld_reg[i]  <= ld_reg[i-1];
        rd_reg[i]  <= rd_reg[i-1];
      end
      // A stalled or flushed decode slot enters the pipe as a bubble.
      vld_reg[0] <= bus.id_valid && !stall_next && !bus.flush;
      we_reg[0]  <= bus.id_we;
      ld_reg[0]  <= bus.id_load;
      rd_reg[0]  <= bus.id_rd_n;
      if (stall_next && !(&cnt_reg)) cnt_reg <= cnt_reg + 1'b1;
    end else if (bus.flush) begin
      vld_reg[0] <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pipe_fwd_ctl.sv
// Directed checks of forwarding select, load-use stall, pause/flush and reset behaviour.
module tb_pipe_fwd_ctl;
  localparam int RN_W     = 5;
  localparam int FW_DEPTH = 3;
  localparam int CNT_W    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_run  = 0;
  int   n_fail = 0;
  int   exp_cnt;

  always #5 clk = ~clk;

  pipe_fwd_ctl_if #(.RN_W(RN_W), .FW_DEPTH(FW_DEPTH), .CNT_W(CNT_W)) bus ();

  pipe_fwd_ctl #(.RN_W(RN_W), .FW_DEPTH(FW_DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic dec(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic we, input logic ld);
    bus.id_valid = v;
    bus.id_rs_n  = rs;
    bus.id_rt_n  = rt;
    bus.id_rd_n  = rd;
    bus.id_we    = we;
    bus.id_load  = ld;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.pause = 1'b0;
    bus.flush = 1'b0;
    // Reset state, with decode inputs that would otherwise look busy
    dec(1, 5'd5, 5'd5, 5'd5, 1, 1);
    #12;
    check("rst_rs_sel", 32'(bus.fw_rs_sel), 0);
    check("rst_rt_sel", 32'(bus.fw_rt_sel), 0);
    check("rst_stall", 32'(bus.stall_o), 0);
    check("rst_cnt", 32'(bus.stall_cnt_o), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // ALU chain
    dec(1, 5'd0, 5'd0, 5'd5, 1, 0);
    tick();
    dec(1, 5'd5, 5'd0, 5'd6, 0, 0);
    check("alu_rs_sel1", 32'(bus.fw_rs_sel), 1);
    check("alu_stall", 32'(bus.stall_o), 0);
    tick();
    dec(1, 5'd0, 5'd5, 5'd0, 0, 0);
    check("alu_rt_sel2", 32'(bus.fw_rt_sel), 2);
    tick();

    // Load-use
    dec(1, 5'd0, 5'd0, 5'd8, 1, 1);
    tick();
    dec(1, 5'd8, 5'd0, 5'd0, 0, 0);
    check("lu_stall", 32'(bus.stall_o), 1);
    check("lu_cnt0", 32'(bus.stall_cnt_o), 0);
    tick();
    check("lu_release", 32'(bus.stall_o), 0);
    check("lu_rs_sel2", 32'(bus.fw_rs_sel), 2);
    check("lu_cnt1", 32'(bus.stall_cnt_o), 1);
    dec(0, 5'd0, 5'd0, 5'd0, 0, 0);
    repeat (4) tick();

    // Priority and non-writer transparency
    dec(1, 5'd0, 5'd0, 5'd3, 1, 0);
    tick();
    dec(1, 5'd0, 5'd0, 5'd7, 1, 0);
    tick();
    dec(1, 5'd0, 5'd0, 5'd3, 1, 0);
    tick();
    dec(1, 5'd3, 5'd7, 5'd3, 0, 0);
    check("prio_rs_young", 32'(bus.fw_rs_sel), 1);
    check("prio_rt_mid", 32'(bus.fw_rt_sel), 2);
    tick();
    dec(1, 5'd0, 5'd0, 5'd0, 1, 0);
    tick();
    dec(1, 5'd0, 5'd3, 5'd0, 0, 0);
    check("r0_never_fwd", 32'(bus.fw_rs_sel), 0);
    check("nonwriter_no_mask", 32'(bus.fw_rt_sel), 3);
    dec(0, 5'd0, 5'd0, 5'd0, 0, 0);
    repeat (4) tick();

    // Pause with flush
    dec(1, 5'd0, 5'd0, 5'd10, 1, 0);
    tick();
    dec(1, 5'd0, 5'd0, 5'd11, 1, 0);
    tick();
    dec(1, 5'd0, 5'd0, 5'd12, 1, 0);
    tick();
    bus.pause = 1'b1;
    bus.flush = 1'b1;
    dec(1, 5'd0, 5'd0, 5'd13, 1, 0);
    repeat (2) tick();
    dec(1, 5'd12, 5'd11, 5'd0, 0, 0);
    check("pf_e0_killed", 32'(bus.fw_rs_sel), 0);
    check("pf_e1_held", 32'(bus.fw_rt_sel), 2);
    dec(1, 5'd10, 5'd13, 5'd0, 0, 0);
    check("pf_e2_held", 32'(bus.fw_rs_sel), 3);
    check("pf_no_new", 32'(bus.fw_rt_sel), 0);
    check("pf_cnt_held", 32'(bus.stall_cnt_o), 1);
    bus.pause = 1'b0;
    bus.flush = 1'b0;
    dec(0, 5'd0, 5'd0, 5'd0, 0, 0);
    repeat (4) tick();

    // Saturation of the 2-bit counter over 5 stall cycles
    exp_cnt = 1;
    for (int r = 0; r < 5; r++) begin
      dec(1, 5'd0, 5'd0, 5'd8, 1, 1);
      tick();
      dec(1, 5'd8, 5'd0, 5'd0, 0, 0);
      check($sformatf("sat_stall%0d", r), 32'(bus.stall_o), 1);
      tick();
      if (exp_cnt < 3) exp_cnt++;
      check($sformatf("sat_cnt%0d", r), 32'(bus.stall_cnt_o), 32'(exp_cnt));
    end

    // Asynchronous reset mid-stall
    dec(1, 5'd0, 5'd0, 5'd9, 1, 1);
    tick();
    dec(1, 5'd9, 5'd8, 5'd0, 0, 0);
    check("ar_pre_stall", 32'(bus.stall_o), 1);
    check("ar_pre_rt_sel", 32'(bus.fw_rt_sel), 3);
    #2;
    rst = 1'b0;
    #1;
    check("ar_stall", 32'(bus.stall_o), 0);
    check("ar_rs_sel", 32'(bus.fw_rs_sel), 0);
    check("ar_rt_sel", 32'(bus.fw_rt_sel), 0);
    check("ar_cnt", 32'(bus.stall_cnt_o), 0);
    @(negedge clk);
    rst = 1'b1;
    dec(1, 5'd0, 5'd0, 5'd4, 1, 0);
    tick();
    dec(1, 5'd4, 5'd0, 5'd0, 0, 0);
    check("post_rst_fwd", 32'(bus.fw_rs_sel), 1);
    check("post_rst_stall", 32'(bus.stall_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
